// File: rtl/lzs_decode_core.sv
// lzs_decode_core
// ---------------
// LZS decompression core. It parses the bit stream presented by the stream
// aligner (13-bit MSB-aligned window) into literals, match offsets and match
// lengths. It replays matches from an internal history RAM and emits every
// decoded byte through a single-entry ready/valid output register.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   clear           synchronous restart (state, history count, pending match)
//   stream_data     bit window, bit 12 is the next unconsumed bit
//   stream_valid    window holds >= 13 valid bits (or the end marker)
//   stream_width    bits consumed this cycle (0,2,4,9,13)
//   stream_ack      consume stream_width bits this cycle
//   out_data/out_valid/out_ready   decoded byte stream with backpressure
//   all_end         end marker parsed and output drained (sticky)
//   error           illegal offset or length overflow (sticky)
//   bytes_out       number of bytes pushed since clear/rst
module lzs_decode_core #(
    parameter int HIST_AW = 11,
    parameter int LEN_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [12:0] stream_data,
    input  logic        stream_valid,
    output logic [3:0]  stream_width,
    output logic        stream_ack,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        all_end,
    output logic        error,
    output logic [31:0] bytes_out
);

    typedef enum logic [3:0] {
        S_IDLE, S_PROC, S_LEN1, S_LEN2, S_LENX, S_COPY, S_DRAIN, S_END, S_ERR
    } state_t;

    localparam logic [HIST_AW:0] HIST_FULL = {1'b1, {HIST_AW{1'b0}}};

    state_t             state_q, state_d;
    logic [HIST_AW-1:0] waddr_q, waddr_d;
    logic [HIST_AW:0]   bw_q, bw_d;          // bytes written, saturating
    logic [31:0]        bytes_out_q, bytes_out_d;
    logic [7:0]         out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic [HIST_AW-1:0] offset_q, offset_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [HIST_AW-1:0] raddr_q, raddr_d;    // address of the most recent read
    logic               rd_vld_q, rd_vld_d;  // RAM output holds data for raddr_q
    logic               fwd_q, fwd_d;        // use fwd_data_q instead of RAM data
    logic [7:0]         fwd_data_q, fwd_data_d;

    logic [7:0]         hist_mem [0:(1<<HIST_AW)-1];
    logic [7:0]         ram_rd_q;
    logic [HIST_AW-1:0] ram_raddr;

    logic               push_ok;
    logic               push;
    logic [7:0]         push_byte;
    logic               start_copy;
    logic [7:0]         copy_byte;
    logic [10:0]        off_sel;
    logic               off_bad;
    logic [LEN_W:0]     len_sum;

    // The output slot is free when empty or being accepted this cycle.
    assign push_ok   = !out_valid_q || out_ready;
    assign copy_byte = fwd_q ? fwd_data_q : ram_rd_q;

    // Offset decode for both offset forms, and its legality against history.
    assign off_sel = stream_data[11] ? {4'b0000, stream_data[10:4]} : stream_data[10:0];
    assign off_bad = (!stream_data[11] && (off_sel == 11'd0)) ||
                     ((HIST_AW+1)'(off_sel) > bw_q);
    assign len_sum = {1'b0, len_q} + (LEN_W+1)'(stream_data[12:9]);

    always_comb begin
        state_d      = state_q;
        waddr_d      = waddr_q;
        bw_d         = bw_q;
        bytes_out_d  = bytes_out_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q && !out_ready;
        offset_d     = offset_q;
        len_d        = len_q;
        raddr_d      = raddr_q;
        rd_vld_d     = 1'b0;
        fwd_d        = 1'b0;
        fwd_data_d   = fwd_data_q;
        stream_ack   = 1'b0;
        stream_width = 4'd0;
        push         = 1'b0;
        push_byte    = 8'h00;
        start_copy   = 1'b0;
        ram_raddr    = raddr_q;

        if (clear) begin
            state_d     = S_IDLE;
            waddr_d     = '0;
            bw_d        = '0;
            bytes_out_d = '0;
            out_valid_d = 1'b0;
            len_d       = '0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_PROC;

                S_PROC: begin
                    if (stream_valid && push_ok) begin
                        stream_ack = 1'b1;
                        if (!stream_data[12]) begin
                            stream_width = 4'd9;
                            push         = 1'b1;
                            push_byte    = stream_data[11:4];
                        end else if (stream_data[12:4] == 9'b110000000) begin
                            stream_width = 4'd9;
                            state_d      = S_DRAIN;
                        end else begin
                            stream_width = stream_data[11] ? 4'd9 : 4'd13;
                            offset_d     = HIST_AW'(off_sel);
                            state_d      = off_bad ? S_ERR : S_LEN1;
                        end
                    end
                end

                S_LEN1: begin
                    if (stream_valid) begin
                        stream_ack   = 1'b1;
                        stream_width = 4'd2;
                        if (stream_data[12:11] == 2'b11) begin
                            state_d = S_LEN2;
                        end else begin
                            len_d      = LEN_W'(stream_data[12:11]) + LEN_W'(2);
                            start_copy = 1'b1;
                        end
                    end
                end

                S_LEN2: begin
                    if (stream_valid) begin
                        stream_ack   = 1'b1;
                        stream_width = 4'd2;
                        len_d        = LEN_W'(stream_data[12:11]) + LEN_W'(5);
                        if (stream_data[12:11] == 2'b11) begin
                            state_d = S_LENX;
                        end else begin
                            start_copy = 1'b1;
                        end
                    end
                end

                S_LENX: begin
                    if (stream_valid) begin
                        stream_ack   = 1'b1;
                        stream_width = 4'd4;
                        if (len_sum[LEN_W]) begin
                            state_d = S_ERR;
                        end else begin
                            len_d = len_sum[LEN_W-1:0];
                            if (stream_data[12:9] != 4'hF) begin
                                start_copy = 1'b1;
                            end
                        end
                    end
                end

                S_COPY: begin
                    if (!rd_vld_q) begin
                        // First read of the match.
                        ram_raddr = raddr_q;
                        rd_vld_d  = 1'b1;
                    end else if (push_ok) begin
                        push      = 1'b1;
                        push_byte = copy_byte;
                        len_d     = len_q - 1'b1;
                        if (len_q == LEN_W'(1)) begin
                            state_d = S_PROC;
                        end else begin
                            ram_raddr  = raddr_q + 1'b1;
                            raddr_d    = raddr_q + 1'b1;
                            rd_vld_d   = 1'b1;
                            // Reading the location written this same cycle:
                            // the RAM returns stale data, so forward the byte.
                            fwd_d      = ((raddr_q + 1'b1) == waddr_q);
                            fwd_data_d = copy_byte;
                        end
                    end else begin
                        // Stalled: re-read the same address. Any write to it
                        // has landed by now, so no forwarding is needed.
                        ram_raddr = raddr_q;
                        rd_vld_d  = 1'b1;
                    end
                end

                S_DRAIN: if (!out_valid_q) state_d = S_END;

                S_END:   state_d = S_END;

                S_ERR:   state_d = S_ERR;

                default: state_d = S_IDLE;
            endcase

            if (start_copy) begin
                state_d  = S_COPY;
                raddr_d  = waddr_q - offset_q;
                rd_vld_d = 1'b0;
            end

            if (push) begin
                out_data_d  = push_byte;
                out_valid_d = 1'b1;
                waddr_d     = waddr_q + 1'b1;
                bw_d        = (bw_q == HIST_FULL) ? bw_q : bw_q + 1'b1;
                bytes_out_d = bytes_out_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            waddr_q     <= '0;
            bw_q        <= '0;
            bytes_out_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            offset_q    <= '0;
            len_q       <= '0;
            raddr_q     <= '0;
            rd_vld_q    <= 1'b0;
            fwd_q       <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            bw_q        <= bw_d;
            bytes_out_q <= bytes_out_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            offset_q    <= offset_d;
            len_q       <= len_d;
            raddr_q     <= raddr_d;
            rd_vld_q    <= rd_vld_d;
            fwd_q       <= fwd_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    // History RAM: one write port (pushed bytes), one registered read port.
    always_ff @(posedge clk) begin
        if (push) begin
            hist_mem[waddr_q] <= push_byte;
        end
        ram_rd_q <= hist_mem[ram_raddr];
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign bytes_out = bytes_out_q;
    assign all_end   = (state_q == S_END);
    assign error     = (state_q == S_ERR);

endmodule

// File: tb/tb_lzs_decode_core.sv
// Testbench for lzs_decode_core: encodes token lists into an LZS bit stream,
// predicts the decoded bytes with a history-replay model, and compares.
module tb_lzs_decode_core;

    logic        clk = 1'b0;
    logic        rst, clear;
    logic [12:0] stream_data;
    logic        stream_valid;
    logic [3:0]  stream_width;
    logic        stream_ack;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        all_end, error;
    logic [31:0] bytes_out;

    always #5 clk = ~clk;

    lzs_decode_core #(.HIST_AW(11), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .stream_data(stream_data), .stream_valid(stream_valid),
        .stream_width(stream_width), .stream_ack(stream_ack),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .all_end(all_end), .error(error), .bytes_out(bytes_out)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         is_match;
        bit         f11;
        logic [7:0] lit;
        int         off;
        int         len;
    } tok_t;

    typedef struct {
        int nlit; int base; int off; int len; bit f11;
        int rmode; int gap_after; bit exp_err; int exp_cnt;
    } vec_t;

    tok_t       toks[$];
    bit         bits_q[$];
    int         exp_w[$], got_w[$];
    logic [7:0] exp_b[$], got_b[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bits_q.push_back(v[i]);
        exp_w.push_back(n);
    endtask

    task automatic add_lit(input logic [7:0] b);
        tok_t t;
        t.is_match = 1'b0; t.f11 = 1'b0; t.lit = b; t.off = 0; t.len = 0;
        toks.push_back(t);
    endtask

    task automatic add_match(input int off, input int len, input bit f11);
        tok_t t;
        t.is_match = 1'b1; t.f11 = f11; t.lit = 8'h00; t.off = off; t.len = len;
        toks.push_back(t);
    endtask

    // Bit-stream encoder: one push_bits call per expected acknowledge.
    task automatic encode();
        int rem;
        bits_q.delete();
        exp_w.delete();
        foreach (toks[i]) begin
            if (!toks[i].is_match) begin
                push_bits({23'd0, 1'b0, toks[i].lit}, 9);
            end else begin
                if (toks[i].f11 || toks[i].off >= 128)
                    push_bits({19'd0, 2'b10, 11'(toks[i].off)}, 13);
                else
                    push_bits({23'd0, 2'b11, 7'(toks[i].off)}, 9);
                if (toks[i].len <= 4) begin
                    push_bits(toks[i].len - 2, 2);
                end else if (toks[i].len <= 7) begin
                    push_bits(3, 2);
                    push_bits(toks[i].len - 5, 2);
                end else begin
                    push_bits(3, 2);
                    push_bits(3, 2);
                    rem = toks[i].len - 8;
                    while (rem >= 15) begin
                        push_bits(15, 4);
                        rem -= 15;
                    end
                    push_bits(rem, 4);
                end
            end
        end
        push_bits(32'h180, 9);
        for (int i = 0; i < 16; i++) bits_q.push_back(1'b0);
    endtask

    // Reference model: replay the token list over a byte history.
    task automatic model(input bit exp_err);
        exp_b.delete();
        foreach (toks[i]) begin
            if (!toks[i].is_match) begin
                exp_b.push_back(toks[i].lit);
            end else if (exp_err) begin
                break;
            end else begin
                for (int k = 0; k < toks[i].len; k++)
                    exp_b.push_back(exp_b[exp_b.size() - toks[i].off]);
            end
        end
    endtask

    task automatic run_check(input string name, input bit exp_err, input int exp_cnt,
                             input int rmode, input int gap_after);
        int         acks, gap_left, cyc, budget, bad;
        bit         prev_stall;
        logic [7:0] prev_data;
        logic [12:0] w;
        acks = 0; gap_left = 0; cyc = 0; prev_stall = 0; prev_data = 8'h00;
        budget = bits_q.size() + 4 * exp_b.size() + 200;
        got_b.delete();
        got_w.delete();
        while (1) begin
            @(negedge clk);
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            w = '0;
            for (int i = 0; i < 13; i++) if (i < bits_q.size()) w[12-i] = bits_q[i];
            stream_data  = w;
            stream_valid = (bits_q.size() >= 13) && (gap_left == 0);
            #1;
            if (prev_stall) begin
                chk({name, " held_valid"}, 32'(out_valid), 32'd1);
                chk({name, " held_data"}, 32'(out_data), 32'(prev_data));
            end
            if (gap_left > 0) begin
                chk({name, " no_ack_invalid"}, 32'(stream_ack), 32'd0);
                gap_left--;
            end
            if (stream_ack) begin
                got_w.push_back(int'(stream_width));
                for (int i = 0; i < int'(stream_width); i++) void'(bits_q.pop_front());
                acks++;
                if (acks == gap_after) gap_left = 5;
            end
            if (out_valid && out_ready) got_b.push_back(out_data);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (all_end || (error && !out_valid)) break;
            cyc++;
            if (cyc > budget) begin
                checks++; errors++;
                $display("FAIL %s timeout: got no end/error after %0d cycles, required done", name, cyc);
                break;
            end
        end
        chk({name, " error"}, 32'(error), 32'(exp_err));
        chk({name, " all_end"}, 32'(all_end), 32'(!exp_err));
        chk({name, " bytes_out"}, bytes_out, 32'(exp_cnt));
        bad = -1;
        for (int i = 0; i < exp_b.size(); i++)
            if (bad < 0 && (i >= got_b.size() || got_b[i] !== exp_b[i])) bad = i;
        if (bad < 0 && got_b.size() != exp_b.size()) bad = exp_b.size();
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s bytes: first difference at %0d, got %0d bytes required %0d (byte got %0h required %0h)",
                     name, bad, got_b.size(), exp_b.size(),
                     (bad < got_b.size()) ? got_b[bad] : 8'hxx,
                     (bad < exp_b.size()) ? exp_b[bad] : 8'hxx);
        end
        if (!exp_err) begin
            bad = (got_w.size() != exp_w.size()) ? 1 : 0;
            for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
                if (got_w[i] != exp_w[i]) bad = 1;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL %s widths: got %0d acks required %0d (first got %0d required %0d)",
                         name, got_w.size(), exp_w.size(),
                         (got_w.size() > 0) ? got_w[0] : -1, exp_w[0]);
            end
        end
        $display("vector %s: %0d bytes out, error=%0b, all_end=%0b", name, got_b.size(), error, all_end);
        // Restart the core for the next vector.
        @(negedge clk);
        stream_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk({name, " clear_error"}, 32'(error), 32'd0);
        chk({name, " clear_end"}, 32'(all_end), 32'd0);
        chk({name, " clear_bytes"}, bytes_out, 32'd0);
        bits_q.delete();
    endtask

    vec_t vecs[12];

    initial begin
        int cnt, off, len;
        vecs[0]  = '{2,    'h41, 0,    0,     0, 0, 0,    0, 2};
        vecs[1]  = '{1,    'h61, 1,    11,    0, 0, 0,    0, 12};
        vecs[2]  = '{16,   'h00, 16,   4,     1, 0, 0,    0, 20};
        vecs[3]  = '{16,   'h00, 16,   4,     1, 1, 0,    0, 20};
        vecs[4]  = '{3,    'h10, 5,    2,     0, 0, 0,    1, 3};
        vecs[5]  = '{4,    'h20, 0,    2,     1, 0, 0,    1, 4};
        vecs[6]  = '{10,   'h30, 10,   8,     0, 2, 0,    0, 18};
        vecs[7]  = '{5,    'h80, 3,    23,    0, 1, 0,    0, 28};
        vecs[8]  = '{8,    'hF0, 200,  4,     1, 0, 0,    1, 8};
        vecs[9]  = '{130,  'h00, 128,  7,     1, 2, 0,    0, 137};
        vecs[10] = '{2100, 'h00, 2047, 2,     1, 0, 2101, 0, 2102};
        vecs[11] = '{6,    'h55, 2,    65536, 0, 0, 0,    1, 6};

        rst = 1'b1; clear = 1'b0; stream_valid = 1'b0; stream_data = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset stream_ack", 32'(stream_ack), 32'd0);
        chk("reset stream_width", 32'(stream_width), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", 32'(out_data), 32'd0);
        chk("reset all_end", 32'(all_end), 32'd0);
        chk("reset error", 32'(error), 32'd0);
        chk("reset bytes_out", bytes_out, 32'd0);
        $display("reset: outputs checked");
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 12; v++) begin
            toks.delete();
            for (int i = 0; i < vecs[v].nlit; i++) add_lit(8'(vecs[v].base + i));
            if (vecs[v].len > 0) add_match(vecs[v].off, vecs[v].len, vecs[v].f11);
            encode();
            model(vecs[v].exp_err);
            run_check($sformatf("table%0d", v), vecs[v].exp_err, vecs[v].exp_cnt,
                      vecs[v].rmode, vecs[v].gap_after);
            if (v == 0 && got_b.size() >= 2 && got_w.size() >= 3) begin
                chk("t0 byte0", 32'(got_b[0]), 32'h41);
                chk("t0 byte1", 32'(got_b[1]), 32'h42);
                chk("t0 width2", 32'(got_w[2]), 32'd9);
            end
            if (v == 2 && got_b.size() >= 20 && got_w.size() >= 18) begin
                chk("t2 copy0", 32'(got_b[16]), 32'h00);
                chk("t2 copy3", 32'(got_b[19]), 32'h03);
                chk("t2 width_off", 32'(got_w[16]), 32'd13);
                chk("t2 width_len", 32'(got_w[17]), 32'd2);
            end
            if (v == 10 && got_b.size() >= 2102) begin
                chk("t10 wrap0", 32'(got_b[2100]), 32'd53);
                chk("t10 wrap1", 32'(got_b[2101]), 32'd54);
            end
        end

        for (int r = 0; r < 20; r++) begin
            toks.delete();
            cnt = $urandom_range(1, 4);
            for (int i = 0; i < cnt; i++) add_lit(8'($urandom));
            for (int k = 0; k < 8; k++) begin
                if ($urandom_range(0, 2) == 0) begin
                    add_lit(8'($urandom));
                    cnt++;
                end else begin
                    off = $urandom_range(1, (cnt > 2047) ? 2047 : cnt);
                    len = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 40) : $urandom_range(2, 7);
                    add_match(off, len, 1'($urandom_range(0, 1)));
                    cnt += len;
                end
            end
            encode();
            model(1'b0);
            run_check($sformatf("rand%0d", r), 1'b0, exp_b.size(), $urandom_range(0, 2), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
